// File: rtl/spi_reg_initiator.sv
// rtl/spi_reg_initiator.sv - SPI mode-0 target turning {wr_rdn, addr, data} frames into register-bus accesses
// Define SPI_AUTO_INC_EN for address-incrementing multi-word bursts while CS stays low.
module spi_reg_initiator #(
    parameter int REG_W  = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    input  logic [REG_W-1:0]  rdata,
    output logic              ena,
    output logic              we,
    input  logic              ack,
    input  logic              err,
    output logic              bus_err,
    output logic              frame_err,
    output logic              busy
);

`ifdef SPI_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam int SR_W  = (ADDR_W + 1 > REG_W) ? ADDR_W + 1 : REG_W;
    localparam int CNT_W = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, DONE} state_t;

    state_t           state;
    logic             cs_s1, cs_s2, cs_d;
    logic             sclk_s1, sclk_s2, sclk_d;
    logic             mosi_s1, mosi_s2;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-2:0]  rx_sr;
    logic [SR_W-1:0]  rx_next;
    logic [REG_W-2:0] tx_sr;
    logic             word_done;
    logic             ovl;
    logic             sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            {cs_s1, cs_s2, cs_d}       <= 3'b111;
            {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
            {mosi_s1, mosi_s2}         <= 2'b00;
        end else begin
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign rx_next   = {rx_sr, mosi_s2};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            spi_miso  <= 1'b0;
            wr_rdn    <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            ena       <= 1'b0;
            bus_err   <= 1'b0;
            frame_err <= 1'b0;
            word_done <= 1'b0;
            ovl       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        cnt       <= '0;
                        rx_sr     <= '0;
                        word_done <= 1'b0;
                        ovl       <= 1'b0;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next[SR_W-2:0];
                        if (cnt == CMD_LAST) begin
                            cnt    <= '0;
                            wr_rdn <= rx_next[ADDR_W];
                            addr   <= rx_next[ADDR_W-1:0];
                            if (rx_next[ADDR_W]) begin
                                state <= DATA;
                            end else begin
                                ena   <= 1'b1;
                                state <= RD_REQ;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    // A prefetch after a finished burst word is a clean end, not an abort
                    if (cs_rise && !word_done)
                        frame_err <= 1'b1;
                    if (ena && ack) begin
                        ena     <= 1'b0;
                        bus_err <= err;
                        if (cs_s2) begin
                            spi_miso <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_sr    <= rdata[REG_W-2:0];
                            spi_miso <= rdata[REG_W-1];
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        if (cnt != '0 || !word_done)
                            frame_err <= 1'b1;
                        spi_miso <= 1'b0;
                        state    <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next[SR_W-2:0];
                        if (cnt == DATA_LAST) begin
                            cnt       <= '0;
                            word_done <= 1'b1;
                            if (wr_rdn) begin
                                wdata <= rx_next[REG_W-1:0];
                                ena   <= 1'b1;
                                state <= WR_REQ;
                            end else if (AUTO_INC) begin
                                addr  <= addr + 1'b1;
                                ena   <= 1'b1;
                                state <= RD_REQ;
                            end else begin
                                spi_miso <= 1'b0;
                                state    <= DONE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sclk_fall && cnt != '0 && !wr_rdn) begin
                        // The first bit was presented on ack; shift only after it has been sampled
                        spi_miso <= tx_sr[REG_W-2];
                        tx_sr    <= {tx_sr[REG_W-3:0], 1'b0};
                    end
                end
                WR_REQ: begin
                    if (ena && ack) begin
                        ena     <= 1'b0;
                        bus_err <= err;
                        if (cs_s2) begin
                            state <= IDLE;
                        end else if (AUTO_INC) begin
                            addr  <= addr + 1'b1;
                            state <= DATA;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    spi_miso <= 1'b0;
                    if (cs_s2) begin
                        state <= IDLE;
                    end else if (sclk_rise && !ovl) begin
                        frame_err <= 1'b1;
                        ovl       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign we          = ena & wr_rdn;
    assign busy        = ~cs_s2 | ena;
    assign spi_miso_oe = ~spi_cs_n;

endmodule

// File: doc/spi_reg_initiator.md
Name: spi_reg_initiator

Overview:
- SPI target front-end that turns SPI frames into register-bus accesses: the initiator side of the register-bank interface (wr_rdn/addr/wdata/rdata/ena/we/ack/err).
- Sits between the chip SPI pins and the register bank.
- Oversamples SCLK/CS_N/MOSI with clk.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- REG_W, 8, data word width in bits.
- ADDR_W, 7, address width carried in the frame; the top level zero-extends it to the bank address width.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous, active-low reset
- spi_cs_n  in  1  chip select, async to clk, active-low
- spi_sclk  in  1  SPI clock, async to clk
- spi_mosi  in  1  serial data in
- spi_miso  out  1  serial data out (registered)
- spi_miso_oe  out  1  MISO output enable, equals !spi_cs_n, combinational
- wr_rdn  out  1  access direction, 1 = write
- addr  out  ADDR_W  access address
- wdata  out  REG_W  write data
- rdata  in  REG_W  read data, sampled when ack=1
- ena  out  1  access request, held until ack
- we  out  1  write enable, equals ena & wr_rdn
- ack  in  1  access accepted/completed
- err  in  1  access error, valid with ack
- bus_err  out  1  one-cycle pulse when ack=1 and err=1
- frame_err  out  1  one-cycle pulse on an aborted or overlong frame
- busy  out  1  high while CS is active (synchronized) or a request is outstanding

Behaviour:
- Input synchronization: 2-FF synchronizers on cs_n, sclk and mosi, plus one edge-detect register.
  - An SCLK edge is acted on 3 clk after it appears on the pin.
  - Constraint: SCLK high and low times each ≥ 4 clk.
- Frame format: 1 + ADDR_W + REG_W bits = {wr_rdn, addr[ADDR_W-1:0], data[REG_W-1:0]}.
  - Default frame length is 16 bits.
  - MOSI is sampled on SCLK rise.
  - MISO changes on SCLK fall.
- Reset: every output is 0. Exception: spi_miso_oe follows the pin.
- State machine:
  - IDLE: wait for synchronized cs_n fall. Clear the bit counter and shift register, then go to CMD.
  - CMD: shift in 1+ADDR_W bits. After the last one, latch wr_rdn and addr.
    - Read: go to RD_REQ.
    - Write: go to DATA.
  - RD_REQ:
    - Assert ena=1 with wr_rdn=0 until ack.
    - On ack, load rdata into the TX shift register and drive MISO = rdata[REG_W-1].
    - Go to DATA.
    - With ack tied high this takes 1 clk, so MISO is valid before the next rising SCLK edge.
  - DATA: shift REG_W bits.
    - Read: MISO shifts out the next bit on each SCLK fall.
    - Write: the MOSI bits accumulate. After the last bit, latch wdata and go to WR_REQ.
    - Read: after the last bit, go to DONE.
  - WR_REQ: assert ena=1 and we=1 with addr/wdata stable until ack, then go to DONE.
  - DONE: ignore further SCLK edges, hold MISO at 0, and go to IDLE on cs_n rise.
- spi_miso is 0 in IDLE, CMD and DONE.
- ena handshake:
  - addr, wdata and wr_rdn stay constant while ena=1.
  - ena drops the cycle after ack is sampled high.
  - An ack received while ena=0 is ignored.
- Abort: cs_n rises before the frame completes.
  - No write is issued.
  - frame_err pulses for 1 clk.
  - Return to IDLE.
  - If a request is already outstanding (RD_REQ/WR_REQ), it completes first, then the block goes to IDLE. A pending read result is discarded.
- Overlong frame: any SCLK rise in DONE pulses frame_err once per frame.
- cs_n falling and rising in the same sampled cycle cannot occur after synchronization; no special case is required.
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: SPI_AUTO_INC_EN.
- Defined:
  - While CS stays low after a DATA phase completes and its request is acked, the block re-enters DATA instead of DONE.
  - Each subsequent REG_W-bit word is a further access at addr+1, wrapping to 0 at 2^ADDR_W-1.
  - Reads pre-fetch the next address (RD_REQ) immediately after the previous word's last bit.
  - frame_err is not raised by extra words. It is raised only for a partial word at cs_n rise.
- Not defined: DONE behaviour as above; extra bits are ignored and flagged.

Test Plan:
- Write frame 1_0000011_10100101, ack tied 1 -> exactly one clk with ena=1, we=1, wr_rdn=1, addr=0x03, wdata=0xA5, ≤4 clk after the 16th SCLK rise; frame_err=0.
- Read frame 0_1000101_xxxxxxxx, rdata=0x3C -> one ena pulse with wr_rdn=0, addr=0x45 after the 8th rise; MISO sampled on rises 9..16 = 0,0,1,1,1,1,0,0.
- ack delayed 3 clk on a write of 0x5A to 0x10 -> ena/we held 4 clk with addr/wdata stable; with err=1 on ack -> bus_err pulses 1 clk.
- cs_n raised after 10 bits of a write -> no ena, frame_err 1 clk; the next full write of 0x11 to 0x01 behaves normally.
- rstb asserted mid-frame (bit 5) -> all outputs 0 immediately; after release, a new frame works.
- SPI_AUTO_INC_EN: 3-word write burst at 0x7E with data 0x01,0x02,0x03 -> accesses at 0x7E, 0x7F, 0x00 with those data; no frame_err.
